lfsr: RTL and testbench

LFSR -- requirements
Module: lfsr

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_next.sv | 25 ++
 rtl/lfsr.sv | 61 ++++++
 tb/tb_lfsr.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and the maximal-length tap table for the lfsr block.
package lfsr_pkg;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 16;

    // Tap mask for a Fibonacci LFSR shifting toward the MSB.
    // Bit i set means state[i] feeds the XOR. A polynomial term x^e maps to mask bit e-1.
    function automatic logic [MAX_WIDTH-1:0] taps_for(input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        case (width)
            2:       mask = 16'h0003;  // x^2+x+1
            3:       mask = 16'h0006;  // x^3+x^2+1
            4:       mask = 16'h000C;  // x^4+x^3+1
            5:       mask = 16'h0014;  // x^5+x^3+1
            6:       mask = 16'h0030;  // x^6+x^5+1
            7:       mask = 16'h0060;  // x^7+x^6+1
            8:       mask = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       mask = 16'h0110;  // x^9+x^5+1
            10:      mask = 16'h0240;  // x^10+x^7+1
            11:      mask = 16'h0500;  // x^11+x^9+1
            12:      mask = 16'h0829;  // x^12+x^6+x^4+x+1
            13:      mask = 16'h100D;  // x^13+x^4+x^3+x+1
            14:      mask = 16'h2015;  // x^14+x^5+x^3+x+1
            15:      mask = 16'h6000;  // x^15+x^14+1
            16:      mask = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state logic for the Fibonacci LFSR: seed load or one shift.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned     WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(taps_for(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    output logic [WIDTH-1:0] next_c
);

    logic feedback;

    // Load takes precedence over the shift; shift moves toward the MSB with feedback into bit 0.
    always_comb begin
        feedback = ^(state & TAPS);
        next_c   = {state[WIDTH-2:0], feedback};
        if (load) begin
            next_c = seed;
        end
    end

endmodule

// File: rtl/lfsr.sv
// Fibonacci LFSR with serial output q = state MSB and a synchronous seed load.
// Optional macro LFSR_LOCKUP_GUARD_EN: any all-zero next state (zero seed or
// zero state) is replaced by RESET_VALUE so the register can never lock up.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(taps_for(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
    output logic             q,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load
);

    // Reject illegal configurations at elaboration.
    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("lfsr: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
    end
    if (RESET_VALUE == '0) begin : g_bad_reset
        $error("lfsr: RESET_VALUE must be nonzero");
    end

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] next_c;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state  (state_q),
        .seed   (seed),
        .load   (load),
        .next_c (next_c)
    );

    // Next register value, optionally steering an all-zero result back to RESET_VALUE.
    always_comb begin
        state_d = next_c;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (next_c == '0) begin
            state_d = RESET_VALUE;
        end
`endif
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q[WIDTH-1];

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr (WIDTH=4 defaults): directed vectors plus a per-cycle model compare.
module tb_lfsr;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] seed;
    logic       q;

    int checks   = 0;
    int failures = 0;
    bit clk_run  = 1'b0;
    bit cmp_en   = 1'b0;

    int unsigned m_state;
    int unsigned lit_q [10] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1};

    lfsr dut (
        .q    (q),
        .clk  (clk),
        .rst  (rst),
        .seed (seed),
        .load (load)
    );

    // Gated clock so the reset pulse can be applied with clk held low.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: x^4+x^3+1 as integer arithmetic (double mod 16, feedback = parity of bits 3 and 2).
    function automatic int unsigned model_step(input int unsigned s, input bit ld, input int unsigned sd);
        int unsigned n;
        if (ld) n = sd;
        else    n = ((s * 2) % 16) + (int'($countones(s & 12)) % 2);
`ifdef LFSR_LOCKUP_GUARD_EN
        if (n == 0) n = 1;
`endif
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_state = 1;
        else     m_state = model_step(m_state, load, 32'(seed));
    end

    // Per-cycle compare of DUT against model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_q", 32'(q), (m_state / 8) % 2);
            check("model_state", 32'(dut.state_q), m_state);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit [15:0] seen;
        rst  = 1'b0;
        load = 1'b0;
        seed = 4'd0;

        // Reset pulse with no clock edge.
        #1 rst = 1'b1;
        #5;
        check("rst_q", 32'(q), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd1);
        #5 rst = 1'b0;
        #1;
        check("rst_release_state", 32'(dut.state_q), 32'd1);
        clk_run = 1'b1;
        cmp_en  = 1'b1;

        // Load 0011 then shift; q after each edge.
        @(negedge clk);
        seed = 4'b0011;
        load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            load = 1'b0;
            check("q_seq", 32'(q), lit_q[i]);
        end
        check("seq_end_state", 32'(dut.state_q), 32'hC);

        // Full period from 0011.
        @(negedge clk);
        seed = 4'b0011;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen[dut.state_q] = 1'b1;
        end
        check("period_end", 32'(dut.state_q), 32'h3);
        check("period_distinct", 32'($countones(seen)), 32'd15);
        check("period_no_zero", 32'(seen[0]), 32'd0);

        // Mid-sequence load of 1010.
        repeat (3) @(negedge clk);
        seed = 4'b1010;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("midload_state", 32'(dut.state_q), 32'hA);
        check("midload_q", 32'(q), 32'd1);
        @(negedge clk);
        check("midload_shift", 32'(dut.state_q), 32'h5);

        // Held load reloads every edge.
        seed = 4'b1001;
        load = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_load", 32'(dut.state_q), 32'h9);
        end
        load = 1'b0;
        @(negedge clk);
        check("hold_release_shift", 32'(dut.state_q), 32'h3);

        // Zero seed.
        seed = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        check("zero_seed_guard", 32'(dut.state_q), 32'h1);
`else
        check("zero_seed_state", 32'(dut.state_q), 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("lockup_q", 32'(q), 32'd0);
            check("lockup_state", 32'(dut.state_q), 32'h0);
        end
`endif

        // Async reset between edges while shifting with load high.
        seed = 4'b0110;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        seed = 4'b1001;
        load = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(dut.state_q), 32'h1);
        check("async_rst_q", 32'(q), 32'd0);
        @(negedge clk);
        check("rst_beats_load", 32'(dut.state_q), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_load", 32'(dut.state_q), 32'h9);
        load = 1'b0;
        @(negedge clk);
        check("post_rst_shift", 32'(dut.state_q), 32'h3);

        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
